// File: rtl/reaction_delay_timer_if.sv
// Signal bundle between the game controller/random source and the reaction timer.
// master drives the requests and delay; slave (the timer) drives LED and result.
interface reaction_delay_timer_if;
  logic        start;
  logic        button;
  logic [12:0] random_value;
  logic        led_on;
  logic [13:0] reaction_time;
  logic        valid;
  logic        foul;
  logic        busy;

  modport master (
    output start,
    output button,
    output random_value,
    input  led_on,
    input  reaction_time,
    input  valid,
    input  foul,
    input  busy
  );

  modport slave (
    input  start,
    input  button,
    input  random_value,
    output led_on,
    output reaction_time,
    output valid,
    output foul,
    output busy
  );
endinterface

// File: rtl/reaction_delay_timer.sv
// Reaction timer: clamps a random delay, counts it down in ms, lights the LED,
// then measures ms until the button press (or times out); early press is a foul.
module reaction_delay_timer #(
  parameter int ClksPerMs = 1000,
  parameter int MinValue  = 1000,
  parameter int MaxValue  = 6000,
  parameter int MaxReact  = 9999
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  reaction_delay_timer_if.slave io_bus
);

  localparam int PsW = (ClksPerMs > 1) ? $clog2(ClksPerMs) : 1;

  localparam logic [PsW-1:0] PS_LAST = PsW'(ClksPerMs - 1);
  localparam logic [12:0]    MIN_V   = 13'(MinValue);
  localparam logic [12:0]    MAX_V   = 13'(MaxValue);
  localparam logic [13:0]    MAX_RT  = 14'(MaxReact);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_REACT = 3'd2,
    ST_DONE  = 3'd3,
    ST_FOUL  = 3'd4
  } state_t;

  state_t         r_state;
  logic [PsW-1:0] r_prescale;
  logic [12:0]    r_delay;
  logic [13:0]    r_react;
  logic           r_led;
  logic [13:0]    r_rt;
  logic           r_valid;
  logic           r_foul;
  logic           r_busy;

  state_t         w_state_nxt;
  logic [PsW-1:0] w_prescale_nxt;
  logic [12:0]    w_delay_nxt;
  logic [13:0]    w_react_nxt;
  logic           w_led_nxt;
  logic [13:0]    w_rt_nxt;
  logic           w_valid_nxt;
  logic           w_foul_nxt;
  logic           w_busy_nxt;

  logic           w_tick;
  logic [12:0]    w_clamped;
  logic [13:0]    w_react_inc;

  assign w_tick      = (r_prescale == PS_LAST);
  assign w_react_inc = r_react + {13'd0, w_tick};

  always_comb begin
    w_clamped = io_bus.random_value;
    if (io_bus.random_value < MIN_V) begin
      w_clamped = MIN_V;
    end else if (io_bus.random_value > MAX_V) begin
      w_clamped = MAX_V;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_prescale_nxt = '0;
    w_delay_nxt    = r_delay;
    w_react_nxt    = r_react;
    w_led_nxt      = r_led;
    w_rt_nxt       = r_rt;
    w_valid_nxt    = r_valid;
    w_foul_nxt     = r_foul;
    w_busy_nxt     = r_busy;

    // The ms prescaler only free-runs while a round is in progress.
    if (r_state == ST_WAIT || r_state == ST_REACT) begin
      w_prescale_nxt = w_tick ? '0 : r_prescale + 1'b1;
    end

    case (r_state)
      ST_IDLE, ST_DONE, ST_FOUL: begin
        if (io_bus.start) begin
          w_state_nxt    = ST_WAIT;
          w_delay_nxt    = w_clamped;
          w_prescale_nxt = '0;
          w_valid_nxt    = 1'b0;
          w_foul_nxt     = 1'b0;
          w_rt_nxt       = '0;
          w_led_nxt      = 1'b0;
          w_busy_nxt     = 1'b1;
        end
      end
      ST_WAIT: begin
        if (io_bus.button) begin
          w_state_nxt    = ST_FOUL;
          w_foul_nxt     = 1'b1;
          w_busy_nxt     = 1'b0;
          w_rt_nxt       = '0;
          w_prescale_nxt = '0;
        end else if (w_tick) begin
          if (r_delay == 13'd1) begin
            w_state_nxt    = ST_REACT;
            w_led_nxt      = 1'b1;
            w_react_nxt    = '0;
            w_prescale_nxt = '0;
          end else begin
            w_delay_nxt = r_delay - 13'd1;
          end
        end
      end
      ST_REACT: begin
        // Saturation wins over a press landing on the same edge.
        if (w_react_inc >= MAX_RT) begin
          w_state_nxt    = ST_DONE;
          w_rt_nxt       = MAX_RT;
          w_react_nxt    = MAX_RT;
          w_valid_nxt    = 1'b1;
          w_led_nxt      = 1'b0;
          w_busy_nxt     = 1'b0;
          w_prescale_nxt = '0;
        end else if (io_bus.button) begin
          w_state_nxt    = ST_DONE;
          w_rt_nxt       = w_react_inc;
          w_react_nxt    = w_react_inc;
          w_valid_nxt    = 1'b1;
          w_led_nxt      = 1'b0;
          w_busy_nxt     = 1'b0;
          w_prescale_nxt = '0;
        end else begin
          w_react_nxt = w_react_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_prescale <= '0;
      r_delay    <= '0;
      r_react    <= '0;
      r_led      <= 1'b0;
      r_rt       <= '0;
      r_valid    <= 1'b0;
      r_foul     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_prescale <= w_prescale_nxt;
      r_delay    <= w_delay_nxt;
      r_react    <= w_react_nxt;
      r_led      <= w_led_nxt;
      r_rt       <= w_rt_nxt;
      r_valid    <= w_valid_nxt;
      r_foul     <= w_foul_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign io_bus.led_on        = r_led;
  assign io_bus.reaction_time = r_rt;
  assign io_bus.valid         = r_valid;
  assign io_bus.foul          = r_foul;
  assign io_bus.busy          = r_busy;

endmodule

// File: tb/tb_reaction_delay_timer.sv
// Directed bench for reaction_delay_timer: a cycle-time model predicts outputs
// every cycle, and literal expectations pin key edges of each scenario.
module tb_reaction_delay_timer;
  localparam int C    = 4;
  localparam int MINV = 1000;
  localparam int MAXV = 6000;
  localparam int MAXR = 9999;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_REACT = 2;
  localparam int M_DONE  = 3;
  localparam int M_FOUL  = 4;

  logic clk = 1'b0;
  logic rst;

  reaction_delay_timer_if bus ();

  reaction_delay_timer #(
    .ClksPerMs(C),
    .MinValue (MINV),
    .MaxValue (MAXV),
    .MaxReact (MAXR)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model state: the round is described by the edge at which the LED must light.
  int m_mode    = M_IDLE;
  int m_led_cyc = 0;
  int m_led     = 0;
  int m_rt      = 0;
  int m_valid   = 0;
  int m_foul    = 0;
  int m_busy    = 0;

  always @(posedge clk) begin
    int d;
    int ms;
    cyc = cyc + 1;
    if (rst) begin
      m_mode = M_IDLE; m_led = 0; m_rt = 0; m_valid = 0; m_foul = 0; m_busy = 0;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE, M_FOUL: begin
          if (bus.start) begin
            d = int'(bus.random_value);
            if (d < MINV) d = MINV;
            if (d > MAXV) d = MAXV;
            m_led_cyc = cyc + d * C;
            m_mode = M_WAIT; m_valid = 0; m_foul = 0; m_rt = 0; m_busy = 1; m_led = 0;
          end
        end
        M_WAIT: begin
          if (bus.button) begin
            m_mode = M_FOUL; m_foul = 1; m_busy = 0; m_rt = 0;
          end else if (cyc == m_led_cyc) begin
            m_mode = M_REACT; m_led = 1;
          end
        end
        M_REACT: begin
          ms = (cyc - m_led_cyc) / C;
          if (ms >= MAXR) begin
            m_mode = M_DONE; m_rt = MAXR; m_valid = 1; m_led = 0; m_busy = 0;
          end else if (bus.button) begin
            m_mode = M_DONE; m_rt = ms; m_valid = 1; m_led = 0; m_busy = 0;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [17:0] act;
    logic [17:0] exp_v;
    if (cyc >= 1) begin
      act   = {bus.led_on, bus.reaction_time, bus.valid, bus.foul, bus.busy};
      exp_v = {m_led[0], 14'(m_rt), m_valid[0], m_foul[0], m_busy[0]};
      checks = checks + 1;
      if (act !== exp_v) begin
        errors = errors + 1;
        $display("FAIL model cyc=%0d {led,rt,valid,foul,busy}: got %0d,%0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d,%0d",
                 cyc, bus.led_on, bus.reaction_time, bus.valid, bus.foul, bus.busy,
                 m_led, m_rt, m_valid, m_foul, m_busy);
      end
    end
  end

  task automatic goto_cyc(input int k);
    @(negedge clk);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks = checks + 1;
    if (got != want) begin
      errors = errors + 1;
      $display("FAIL %s cyc=%0d: got %0d want %0d", name, cyc, got, want);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.button = 1'b0;
    bus.random_value = '0;

    goto_cyc(4);
    chk("reset_led", int'(bus.led_on), 0);
    chk("reset_rt", int'(bus.reaction_time), 0);
    chk("reset_valid", int'(bus.valid), 0);
    chk("reset_busy", int'(bus.busy), 0);
    rst = 1'b0;

    // Nominal round: start at edge 10, LED at 4010, press at 5010 -> 250 ms.
    goto_cyc(9);  bus.start = 1'b1; bus.random_value = 13'd1000;
    goto_cyc(10); bus.start = 1'b0;
    chk("r1_busy", int'(bus.busy), 1);
    goto_cyc(4009); chk("r1_led_pre", int'(bus.led_on), 0);
    goto_cyc(4010); chk("r1_led_on", int'(bus.led_on), 1);
    goto_cyc(5009); bus.button = 1'b1;
    goto_cyc(5010); bus.button = 1'b0;
    chk("r1_valid", int'(bus.valid), 1);
    chk("r1_rt", int'(bus.reaction_time), 250);
    chk("r1_led_off", int'(bus.led_on), 0);
    chk("r1_busy_off", int'(bus.busy), 0);

    // Start+Button together, low clamp, stray Start pulses mid-round.
    goto_cyc(5019); bus.start = 1'b1; bus.button = 1'b1; bus.random_value = 13'd200;
    goto_cyc(5020); bus.start = 1'b0; bus.button = 1'b0;
    chk("r2_no_foul", int'(bus.foul), 0);
    chk("r2_busy", int'(bus.busy), 1);
    goto_cyc(5499); bus.start = 1'b1;
    goto_cyc(5500); bus.start = 1'b0;
    goto_cyc(9019); chk("r2_led_pre", int'(bus.led_on), 0);
    goto_cyc(9020); chk("r2_led_on", int'(bus.led_on), 1);
    goto_cyc(9029); bus.start = 1'b1;
    goto_cyc(9030); bus.start = 1'b0;
    goto_cyc(9061); bus.button = 1'b1;
    goto_cyc(9062); bus.button = 1'b0;
    chk("r2_rt", int'(bus.reaction_time), 10);
    chk("r2_valid", int'(bus.valid), 1);

    // High clamp to 6000 ms, then reset mid-REACT.
    goto_cyc(9099); bus.start = 1'b1; bus.random_value = 13'd8000;
    goto_cyc(9100); bus.start = 1'b0;
    goto_cyc(33099); chk("r3_led_pre", int'(bus.led_on), 0);
    goto_cyc(33100); chk("r3_led_on", int'(bus.led_on), 1);
    goto_cyc(33119); rst = 1'b1;
    goto_cyc(33120); rst = 1'b0;
    chk("r3_rst_led", int'(bus.led_on), 0);
    chk("r3_rst_busy", int'(bus.busy), 0);
    chk("r3_rst_valid", int'(bus.valid), 0);

    // Fresh round after reset, early press -> foul.
    goto_cyc(33129); bus.start = 1'b1; bus.random_value = 13'd3000;
    goto_cyc(33130); bus.start = 1'b0;
    chk("r4_busy", int'(bus.busy), 1);
    goto_cyc(33229); bus.button = 1'b1;
    goto_cyc(33230); bus.button = 1'b0;
    chk("r4_foul", int'(bus.foul), 1);
    chk("r4_rt", int'(bus.reaction_time), 0);
    chk("r4_busy_off", int'(bus.busy), 0);
    chk("r4_led", int'(bus.led_on), 0);

    // Next start clears foul; no press -> timeout at 9999 ms.
    goto_cyc(33299); bus.start = 1'b1; bus.random_value = 13'd1000;
    goto_cyc(33300); bus.start = 1'b0;
    chk("r5_foul_clr", int'(bus.foul), 0);
    goto_cyc(37300); chk("r5_led_on", int'(bus.led_on), 1);
    goto_cyc(77295);
    chk("r5_valid_pre", int'(bus.valid), 0);
    chk("r5_led_pre", int'(bus.led_on), 1);
    goto_cyc(77296);
    chk("r5_valid", int'(bus.valid), 1);
    chk("r5_rt", int'(bus.reaction_time), 9999);
    chk("r5_led_off", int'(bus.led_on), 0);

    goto_cyc(77300);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
